// File: rtl/decoder_n_to_m_seq_if.sv
// Bus bundle for the registered N-to-M decoder: control and index inputs
// plus the registered decode, valid flag, index readback and range flag.
interface decoder_n_to_m_seq_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
);
  logic             enable;
  logic [1:0]       mode;
  logic [IN_W-1:0]  in;
  logic             in_valid;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic [IN_W-1:0]  sel_q;
  logic             range_err;

  modport master (
    output enable, mode, in, in_valid,
    input  out, out_valid, sel_q, range_err
  );

  modport slave (
    input  enable, mode, in, in_valid,
    output out, out_valid, sel_q, range_err
  );
endinterface

// File: rtl/decoder_n_to_m_seq.sv
// Registered N-to-M decoder with one-hot, thermometer, auto-scan and
// active-low one-hot modes. Every output comes straight from a flop, so
// there is no combinational path from the inputs to the outputs.
module decoder_n_to_m_seq #(
  parameter int IN_W     = 3,
  parameter int OUT_W    = 8,
  parameter int SCAN_DIV = 4
) (
  input logic                clk,
  input logic                rst,
  decoder_n_to_m_seq_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ONEHOT   = 2'd0,
    MODE_THERM    = 2'd1,
    MODE_SCAN     = 2'd2,
    MODE_ONEHOT_N = 2'd3
  } mode_t;

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CMP_W = (IN_W > $clog2(OUT_W)) ? IN_W : $clog2(OUT_W);
  localparam int RNG_W = CMP_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [RNG_W-1:0] OUT_W_EXT = RNG_W'(OUT_W);
  localparam logic [RNG_W-1:0] LAST_IDX  = RNG_W'(OUT_W - 1);

  mode_t            cur_mode;
  logic [IN_W-1:0]  sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;
  logic             range_err_q;

  logic [IN_W-1:0]  idx_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CMP_W-1:0] idx_cmp;
  logic             in_range;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] therm;
  logic [OUT_W-1:0] out_d;
  logic             out_valid_d;
  logic             range_err_d;

  assign cur_mode = mode_t'(bus.mode);

  // Next index and scan divider: loads outside scan mode, divided stepping
  // with wrap inside it, and everything frozen while the block is disabled.
  always_comb begin
    idx_next = sel_q;
    cnt_next = cnt_q;
    if (cur_mode != MODE_SCAN) begin
      cnt_next = '0;
      if (bus.enable && bus.in_valid) begin
        idx_next = bus.in;
      end
    end else if (bus.enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_next = '0;
        if (RNG_W'(sel_q) >= LAST_IDX) begin
          idx_next = '0;
        end else begin
          idx_next = sel_q + 1'b1;
        end
      end else begin
        cnt_next = cnt_q + 1'b1;
      end
    end
  end

  // Decode of the upcoming index; an out-of-range index drives every output
  // to its inactive level and raises the range flag alongside it.
  always_comb begin
    idx_cmp     = CMP_W'(idx_next);
    in_range    = (RNG_W'(idx_next) < OUT_W_EXT);
    onehot      = '0;
    therm       = '0;
    out_d       = '0;
    out_valid_d = 1'b0;
    range_err_d = range_err_q;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = (idx_cmp == CMP_W'(i));
      therm[i]  = (idx_cmp >= CMP_W'(i));
    end
    if (!bus.enable) begin
      if (cur_mode == MODE_ONEHOT_N) begin
        out_d = '1;
      end
    end else begin
      out_valid_d = 1'b1;
      range_err_d = !in_range;
      case (cur_mode)
        MODE_THERM:    out_d = in_range ? therm : '0;
        MODE_ONEHOT_N: out_d = in_range ? ~onehot : '1;
        default:       out_d = in_range ? onehot : '0;
      endcase
    end
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      sel_q       <= idx_next;
      cnt_q       <= cnt_next;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_q     = sel_q;
  assign bus.range_err = range_err_q;

endmodule
